// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: RV32/64 M-extension unit, single-cycle multiply and
// radix-2 restoring divide (one quotient bit per cycle) with tagged results.
module rv_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             done_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [TAG_W-1:0] tag_q, tag_d, tago_q, tago_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d;
  logic accept, sdiv, a_neg, b_neg, spec_zero, spec_ovf;
  logic [XLEN-1:0] spec_res, a_mag, b_mag, rem_n, quo_n, div_res, mul_res;
  logic [XLEN:0] trial;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  assign ready_o  = (state_q == IDLE || state_q == DONE) && !rst;
  assign busy_o   = state_q == MUL || state_q == DIV;
  assign done_o   = state_q == DONE;
  assign result_o = res_q;
  assign tag_o    = tago_q;
  assign accept   = valid_i && ready_o && !flush_i;
  assign sdiv      = !op_i[0];
  assign a_neg     = sdiv && a_i[XLEN-1];
  assign b_neg     = sdiv && b_i[XLEN-1];
  assign a_mag     = a_neg ? -a_i : a_i;
  assign b_mag     = b_neg ? -b_i : b_i;
  assign spec_zero = b_i == '0;
  assign spec_ovf  = sdiv && a_i == MIN && &b_i;
  assign spec_res  = spec_zero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : a_i);
  // MULHU treats a as unsigned; only MULH treats b as signed.
  assign a_ext   = {{XLEN{a_q[XLEN-1] && op_q[1:0] != 2'b11}}, a_q};
  assign b_ext   = {{XLEN{b_q[XLEN-1] && op_q[1:0] == 2'b01}}, b_q};
  assign prod    = a_ext * b_ext;
  assign mul_res = op_q == 3'b000 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign trial   = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
  assign rem_n   = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
  assign quo_n   = {quo_q[XLEN-2:0], !trial[XLEN]};
  assign div_res = op_q[1] ? (rneg_q ? -rem_n : rem_n) : (qneg_q ? -quo_n : quo_n);
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    res_d   = res_q;
    tago_d  = tago_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    if (flush_i) begin
      state_d = IDLE;
    end else if (accept) begin
      op_d  = op_i;
      a_d   = a_i;
      b_d   = b_i;
      tag_d = tag_i;
      if (!op_i[2]) begin
        state_d = MUL;
      end else if (spec_zero || spec_ovf) begin
        state_d = DONE;
        res_d   = spec_res;
        tago_d  = tag_i;
      end else begin
        state_d = DIV;
        rem_d   = '0;
        quo_d   = a_mag;
        dvs_d   = b_mag;
        cnt_d   = '0;
        qneg_d  = a_neg ^ b_neg;
        rneg_d  = a_neg;
      end
    end else begin
      case (state_q)
        MUL: begin
          state_d = DONE;
          res_d   = mul_res;
          tago_d  = tag_q;
        end
        DIV: begin
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) begin
            state_d = DONE;
            res_d   = div_res;
            tago_d  = tag_q;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      tago_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      tago_q  <= tago_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb_rv_muldiv_unit: scoreboard bench for rv_muldiv_unit (XLEN=32) against an
// arithmetic reference model; a monitor checks result, tag and latency.
module tb_rv_muldiv_unit;
  logic        clk = 0, rst = 1, valid_i = 0, flush_i = 0;
  logic [2:0]  op_i = 0;
  logic [31:0] a_i = 0, b_i = 0;
  logic [4:0]  tag_i = 0;
  logic        ready_o, done_o, busy_o;
  logic [31:0] result_o;
  logic [4:0]  tag_o;
  typedef struct { logic [31:0] res; logic [4:0] tag; int acc; int lat; } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [31:0] last_res = 0;
  logic [4:0]  last_tag = 0;
  rv_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .tag_i(tag_i), .flush_i(flush_i), .done_o(done_o),
    .result_o(result_o), .tag_o(tag_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endfunction
  function automatic logic [31:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: return b == 0 ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic int lat_of(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 200));
      default: return $urandom;
    endcase
  endfunction
  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", result_o, e.res);
        check("tag", 32'(tag_o), 32'(e.tag));
        check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        last_res = e.res;
        last_tag = e.tag;
      end
    end
  end
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input bit expect_done);
    int n = 0;
    valid_i = 1; op_i = op; a_i = a; b_i = b; tag_i = tag; flush_i = 0;
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) check("ready_timeout", 32'h0, 32'h1);
    if (expect_done) q.push_back('{model(op, a, b), tag, cyc + 1, lat_of(op, a, b)});
    @(negedge clk);
    valid_i = 0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom; tag_i = 5'($urandom);
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done_o) check("done_timeout", 32'h0, 32'h1);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(q.size()), 32'h0);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    logic [31:0] held;
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] held;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready_o), 32'h0);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_result", result_o, 32'h0);
    check("rst_tag", 32'(tag_o), 32'h0);
    rst = 0;
    @(negedge clk);
    check("post_rst_ready", 32'(ready_o), 32'h1);
    send(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 1); drain();
    send(3'd0, 32'h8000_0000, 32'h8000_0000, 5'd2, 1); drain();
    send(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1); drain();
    send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1); drain();
    send(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1); drain();
    send(3'd4, 32'd7, 32'd0, 5'd6, 1); drain();
    send(3'd5, 32'd7, 32'd0, 5'd7, 1); drain();
    send(3'd6, 32'd7, 32'd0, 5'd8, 1); drain();
    send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1); drain();
    send(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1); drain();
    send(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd11, 1); drain();
    send(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd12, 1); drain();
    send(3'd5, 32'd100, 32'd7, 5'd13, 1); drain();
    send(3'd5, 32'd1000, 32'd9, 5'd14, 1);
    wait_done();
    send(3'd0, 32'd6, 32'd7, 5'd15, 1);
    drain();
    held = result_o;
    send(3'd4, 32'd12345, 32'd17, 5'd16, 0);
    repeat (9) @(negedge clk);
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    check("flush_ready", 32'(ready_o), 32'h1);
    check("flush_busy", 32'(busy_o), 32'h0);
    repeat (40) @(negedge clk);
    check("flush_result_held", result_o, held);
    send(3'd0, 32'd3, 32'd5, 5'd17, 1); drain();
    for (int i = 0; i < 150; i++) begin
      send(3'($urandom), pick(), pick(), 5'($urandom), 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    drain();
    check("hold_result", result_o, last_res);
    check("hold_tag", 32'(tag_o), 32'(last_tag));
    send(3'd5, 32'd99999, 32'd13, 5'd18, 0);
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("midrst_ready", 32'(ready_o), 32'h0);
    check("midrst_busy", 32'(busy_o), 32'h0);
    check("midrst_result", result_o, 32'h0);
    check("midrst_tag", 32'(tag_o), 32'h0);
    rst = 0;
    @(negedge clk);
    check("midrst_ready_after", 32'(ready_o), 32'h1);
    repeat (40) @(negedge clk);
    check("midrst_no_done_result", result_o, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
